// File: rtl/merge_rr_pkg.sv
// Shared types and bus-word geometry for the round-robin request merge.
package merge_rr_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // Response word is {rdata, ready}; ready sits in the LSB.
    localparam int READY_BIT = 0;

    // Request word is {valid, addr, wdata, wstrb}.
    function automatic int req_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w + data_w / 8;
    endfunction

    function automatic int resp_width(input int data_w);
        return data_w + 1;
    endfunction

endpackage

// File: rtl/merge_rr_arbiter.sv
// Combinational round-robin pick: first asserted request scanning ptr, ptr+1, ... mod N.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int NB = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [NB-1:0] ptr,
    output logic [NB-1:0] winner,
    output logic          any
);

    logic [NB-1:0] idx;

    // NOTE: every output of a combinational block gets a default before any branch; a missed path would infer a latch.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        idx    = ptr;
        for (int k = 0; k < N; k++) begin
            if (!any && req[idx]) begin
                winner = idx;
                any    = 1'b1;
            end
            // Explicit wrap so non-power-of-two N never visits an unused index.
            idx = (idx == NB'(N - 1)) ? '0 : idx + NB'(1);
        end
    end

endmodule

// File: rtl/merge_rr.sv
// N-master to 1-slave round-robin merge; grant is held from arbitration until the slave ready pulse.
module merge_rr
    import merge_rr_pkg::*;
#(
    parameter  int N_MASTERS = 2,
    parameter  int DATA_W    = 32,
    parameter  int ADDR_W    = 32,
    localparam int NB        = $clog2(N_MASTERS),
    localparam int REQ_W     = req_width(ADDR_W, DATA_W),
    localparam int RESP_W    = resp_width(DATA_W)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_MASTERS*REQ_W-1:0]  m_req,
    output logic [N_MASTERS*RESP_W-1:0] m_resp,
    output logic [REQ_W-1:0]            s_req,
    input  logic [RESP_W-1:0]           s_resp,
    output logic [NB-1:0]               grant,
    output logic                        busy
);

    localparam int VALID_BIT = REQ_W - 1;

    state_t                 state_q, state_d;
    logic   [NB-1:0]        ptr_q, ptr_d;
    logic   [NB-1:0]        grant_q, grant_d;
    logic   [N_MASTERS-1:0] valids;
    logic   [NB-1:0]        winner;
    logic                   any_valid;
    logic   [REQ_W-1:0]     gnt_req;

    always_comb begin
        valids = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            valids[i] = m_req[i*REQ_W + VALID_BIT];
        end
    end

    rr_arbiter #(
        .N  (N_MASTERS),
        .NB (NB)
    ) u_arb (
        .req    (valids),
        .ptr    (ptr_q),
        .winner (winner),
        .any    (any_valid)
    );

    assign gnt_req = m_req[grant_q*REQ_W +: REQ_W];

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        s_req   = '0;
        m_resp  = '0;
        unique case (state_q)
            IDLE: begin
                if (any_valid) begin
                    grant_d = winner;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                s_req = gnt_req;
                m_resp[grant_q*RESP_W +: RESP_W] = s_resp;
                if (s_resp[READY_BIT]) begin
                    state_d = IDLE;
                    ptr_d   = (grant_q == NB'(N_MASTERS - 1)) ? '0 : grant_q + NB'(1);
                end else if (!gnt_req[VALID_BIT]) begin
                    // Master withdrew before completion: drop it without moving the fairness pointer.
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == BUSY);

endmodule

// File: tb/tb_merge_rr.sv
// Self-checking bench for merge_rr (4 masters) plus a vector table for the 3-way arbiter.
module tb_merge_rr;
    import merge_rr_pkg::*;

    localparam int N      = 4;
    localparam int DW     = 32;
    localparam int AW     = 32;
    localparam int NB     = 2;
    localparam int REQ_W  = req_width(AW, DW);
    localparam int RESP_W = resp_width(DW);

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic [N*REQ_W-1:0]    m_req;
    logic [N*RESP_W-1:0]   m_resp;
    logic [REQ_W-1:0]      s_req;
    logic [RESP_W-1:0]     s_resp;
    logic [NB-1:0]         grant;
    logic                  busy;

    always #5 clk = ~clk;

    merge_rr #(
        .N_MASTERS (N),
        .DATA_W    (DW),
        .ADDR_W    (AW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .m_req  (m_req),
        .m_resp (m_resp),
        .s_req  (s_req),
        .s_resp (s_resp),
        .grant  (grant),
        .busy   (busy)
    );

    logic [2:0] a_req;
    logic [1:0] a_ptr;
    logic [1:0] a_win;
    logic       a_any;

    rr_arbiter #(.N(3), .NB(2)) u_arb3 (
        .req    (a_req),
        .ptr    (a_ptr),
        .winner (a_win),
        .any    (a_any)
    );

    typedef struct {
        logic [2:0] req;
        logic [1:0] ptr;
        logic [1:0] win;
        logic       any;
    } arb_vec_t;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Master models, slave model and scoreboard state.
    logic          mv [N];
    logic [AW-1:0] ma [N];
    logic [DW-1:0] mw [N];
    logic [3:0]    ms [N];
    int            want [N];
    logic [AW-1:0] next_addr [N];
    logic          saw_ready [N];
    int            ready_cnt [N];
    int            slave_delay = 1;
    int            busy_cnt = 0;
    logic [DW-1:0] next_rdata = 32'h1000_0001;
    int            exp_grant_q [$];
    logic [DW-1:0] rdata_q [$];
    int            cur_master = -1;
    logic          prev_busy = 1'b0;
    bit            mon_en = 1'b0;

    task automatic drive_bus();
        for (int i = 0; i < N; i++) begin
            m_req[i*REQ_W +: REQ_W] = {mv[i], ma[i], mw[i], ms[i]};
        end
    endtask

    // One clock: masters retire/issue, slave answers after slave_delay busy cycles.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (saw_ready[i]) mv[i] = 1'b0;
            if (!mv[i] && want[i] > 0) begin
                mv[i]        = 1'b1;
                want[i]      = want[i] - 1;
                ma[i]        = next_addr[i];
                next_addr[i] = next_addr[i] + 32'h4;
                mw[i]        = $urandom();
                ms[i]        = 4'($urandom_range(1, 15));
            end
        end
        s_resp = '0;
        if (busy) begin
            if (busy_cnt == slave_delay) begin
                s_resp = {next_rdata, 1'b1};
                rdata_q.push_back(next_rdata);
                next_rdata = next_rdata + 32'h11;
            end
            busy_cnt++;
        end else begin
            busy_cnt = 0;
        end
        drive_bus();
    endtask

    function automatic bit pending();
        bit p = busy;
        for (int i = 0; i < N; i++) if (want[i] > 0 || mv[i]) p = 1'b1;
        return p;
    endfunction

    task automatic run_until_idle(input int budget, output int n);
        n = 0;
        while (pending() && n < budget) begin
            tick();
            n++;
        end
        check("drain_timeout", (n < budget), 1'b1);
    endtask

    function automatic int total_ready();
        int s = 0;
        for (int i = 0; i < N; i++) s += ready_cnt[i];
        return s;
    endfunction

    // Monitor: grant order, pass-through, response masking and rdata scoreboard.
    always @(negedge clk) begin
        int                e;
        int                bad;
        logic [RESP_W-1:0] r;
        if (!mon_en) begin
            for (int i = 0; i < N; i++) saw_ready[i] <= 1'b0;
            prev_busy <= 1'b0;
        end else begin
            if (busy && !prev_busy) begin
                if (exp_grant_q.size() == 0) begin
                    check("grant_unexpected", grant, 3'h4);
                end else begin
                    e = exp_grant_q.pop_front();
                    check("grant_order", grant, e);
                    cur_master = e;
                end
            end
            if (busy && cur_master >= 0)
                check("s_req_pass", s_req, {mv[cur_master], ma[cur_master], mw[cur_master], ms[cur_master]});
            else if (!busy)
                check("s_req_idle", s_req, 0);
            bad = 0;
            for (int i = 0; i < N; i++) begin
                r = m_resp[i*RESP_W +: RESP_W];
                saw_ready[i] <= r[READY_BIT];
                if (!(busy && i == cur_master) && r != '0) bad++;
                if (r[READY_BIT]) begin
                    ready_cnt[i]++;
                    check("ready_master", i, cur_master);
                    if (rdata_q.size() == 0) check("ready_unexpected", 1'b1, 1'b0);
                    else check("rdata", r[RESP_W-1:1], rdata_q.pop_front());
                end
            end
            check("resp_mask", bad, 0);
            prev_busy <= busy;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        arb_vec_t arb_tab [13];
        int       order_cont [5];
        int       order_fair [4];
        int       n;
        int       r0, r1, rt;

        arb_tab[0]  = '{3'b000, 2'd0, 2'd0, 1'b0};
        arb_tab[1]  = '{3'b001, 2'd0, 2'd0, 1'b1};
        arb_tab[2]  = '{3'b010, 2'd0, 2'd1, 1'b1};
        arb_tab[3]  = '{3'b110, 2'd0, 2'd1, 1'b1};
        arb_tab[4]  = '{3'b100, 2'd0, 2'd2, 1'b1};
        arb_tab[5]  = '{3'b101, 2'd1, 2'd2, 1'b1};
        arb_tab[6]  = '{3'b011, 2'd1, 2'd1, 1'b1};
        arb_tab[7]  = '{3'b001, 2'd1, 2'd0, 1'b1};
        arb_tab[8]  = '{3'b101, 2'd2, 2'd2, 1'b1};
        arb_tab[9]  = '{3'b011, 2'd2, 2'd0, 1'b1};
        arb_tab[10] = '{3'b010, 2'd2, 2'd1, 1'b1};
        arb_tab[11] = '{3'b111, 2'd2, 2'd2, 1'b1};
        arb_tab[12] = '{3'b000, 2'd2, 2'd0, 1'b0};
        order_cont  = '{0, 1, 2, 3, 0};
        order_fair  = '{0, 2, 0, 0};

        for (int i = 0; i < N; i++) begin
            mv[i] = 1'b0; ma[i] = '0; mw[i] = '0; ms[i] = '0;
            want[i] = 0; next_addr[i] = 32'h1000 * (i + 1); ready_cnt[i] = 0;
        end
        s_resp = '0;
        drive_bus();

        for (int v = 0; v < 13; v++) begin
            a_req = arb_tab[v].req;
            a_ptr = arb_tab[v].ptr;
            #1;
            check($sformatf("arb_any[%0d]", v), a_any, arb_tab[v].any);
            if (arb_tab[v].any) check($sformatf("arb_win[%0d]", v), a_win, arb_tab[v].win);
        end

        // Reset, then 10 idle cycles.
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_grant", grant, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        mon_en = 1'b1;
        for (int c = 0; c < 10; c++) begin
            tick();
            @(negedge clk);
            check("idle_s_req", s_req, 0);
            check("idle_busy", busy, 1'b0);
            check("idle_grant", grant, 0);
            check("idle_m_resp", |m_resp, 1'b0);
        end

        // Contention: all four masters, ready in the first busy cycle.
        slave_delay = 0;
        foreach (order_cont[k]) exp_grant_q.push_back(order_cont[k]);
        want[0] = 2; want[1] = 1; want[2] = 1; want[3] = 1;
        run_until_idle(100, n);
        check("contention_cycles", n, 11);
        check("contention_grant_q_left", exp_grant_q.size(), 0);

        // Single master M1 at 0x100, ready two cycles after s_req valid.
        slave_delay = 2;
        next_rdata = 32'hCAFE_F00D;
        next_addr[1] = 32'h100;
        r0 = ready_cnt[0];
        r1 = ready_cnt[1];
        exp_grant_q.push_back(1);
        want[1] = 1;
        tick();
        @(negedge clk);
        check("lat_busy_early", busy, 1'b0);
        check("lat_valid_early", s_req[REQ_W-1], 1'b0);
        tick();
        @(negedge clk);
        check("lat_valid", s_req[REQ_W-1], 1'b1);
        check("lat_addr", s_req[REQ_W-2 -: AW], 32'h100);
        check("lat_grant", grant, 1);
        run_until_idle(50, n);
        tick();
        @(negedge clk);
        check("m1_ready_once", ready_cnt[1] - r1, 1);
        check("m0_no_ready", ready_cnt[0] - r0, 0);

        // Fairness: M0 streams, M2 joins once while M0 is being served.
        slave_delay = 1;
        foreach (order_fair[k]) exp_grant_q.push_back(order_fair[k]);
        want[0] = 3;
        tick();
        tick();
        want[2] = 1;
        run_until_idle(100, n);
        check("fair_grant_q_left", exp_grant_q.size(), 0);

        // Abort: M1 withdraws while granted.
        slave_delay = 100;
        rt = total_ready();
        exp_grant_q.push_back(1);
        want[1] = 1;
        tick();
        tick();
        @(negedge clk);
        check("abort_pre_busy", busy, 1'b1);
        check("abort_pre_grant", grant, 1);
        tick();
        mv[1] = 1'b0;
        drive_bus();
        @(negedge clk);
        check("abort_drop_valid", s_req[REQ_W-1], 1'b0);
        tick();
        @(negedge clk);
        check("abort_idle", busy, 1'b0);
        check("abort_no_ready", total_ready() - rt, 0);
        // Pointer still at 1: M1 beats M0; an advanced pointer would pick M0.
        slave_delay = 1;
        exp_grant_q.push_back(1);
        exp_grant_q.push_back(0);
        want[0] = 1; want[1] = 1;
        run_until_idle(100, n);
        check("abort_grant_q_left", exp_grant_q.size(), 0);

        // Asynchronous reset while M2 is granted.
        slave_delay = 100;
        exp_grant_q.push_back(2);
        want[2] = 1;
        tick();
        tick();
        @(negedge clk);
        check("arst_pre_busy", busy, 1'b1);
        #2;
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        check("arst_busy", busy, 1'b0);
        check("arst_s_req", s_req, 0);
        check("arst_m_resp", |m_resp, 1'b0);
        check("arst_grant", grant, 0);
        for (int i = 0; i < N; i++) begin
            mv[i] = 1'b0; want[i] = 0;
        end
        s_resp = '0;
        busy_cnt = 0;
        drive_bus();
        exp_grant_q.delete();
        rdata_q.delete();
        @(negedge clk);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        mon_en = 1'b1;
        // Pointer back at 0: M0 first; a stale pointer of 1 would pick M1.
        slave_delay = 1;
        exp_grant_q.push_back(0);
        exp_grant_q.push_back(1);
        want[0] = 1; want[1] = 1;
        run_until_idle(100, n);
        tick();
        @(negedge clk);
        check("final_grant_q_left", exp_grant_q.size(), 0);
        check("final_rdata_q_left", rdata_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
